// File: rtl/full_adder_pkg.sv
// full_adder_pkg: shared width default and the one-bit full-adder function
package full_adder_pkg;
  localparam int FA_DEFAULT_WIDTH = 1;
  function automatic logic [1:0] fa_bit(input logic a, input logic b, input logic c);
    return {(a & b) | (c & (a ^ b)), a ^ b ^ c};
  endfunction
endpackage

// File: rtl/fa_cell.sv
// fa_cell: one-bit combinational full adder cell
module fa_cell
  import full_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign {co, s} = fa_bit(a, b, ci);
endmodule

// File: rtl/full_adder.sv
// full_adder: ripple-carry adder of fa_cell; FULL_ADDER_REG_OUT_EN adds a reset-to-0 output register
module full_adder
  import full_adder_pkg::*;
#(
  parameter int WIDTH = FA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;
  assign c[0] = cin;
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    fa_cell u_cell (.a(a[i]), .b(b[i]), .ci(c[i]), .s(s[i]), .co(c[i+1]));
  end
`ifdef FULL_ADDER_REG_OUT_EN
  always_ff @(posedge clk)
    if (rst) {carry, sum} <= '0;
    else     {carry, sum} <= {c[WIDTH], s};
`else
  logic unused_clk_rst;
  assign unused_clk_rst = &{1'b0, clk, rst};
  assign sum   = s;
  assign carry = c[WIDTH];
`endif
endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder: directed and random checks for full_adder at WIDTH 1, 4 and 8
module tb_full_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic       a1, b1, c1, s1, k1;
  logic [3:0] a4, b4, s4;
  logic       c4, k4;
  logic [7:0] a8, b8, s8;
  logic       c8, k8;
  logic [8:0] ref9;
  int n_chk = 0;
  int n_pass = 0;
  logic [4:0]  tt [8];
  logic [25:0] v8 [6];
  full_adder #(.WIDTH(1)) d1 (.clk(clk), .rst(rst), .a(a1), .b(b1), .cin(c1), .sum(s1), .carry(k1));
  full_adder #(.WIDTH(4)) d4 (.clk(clk), .rst(rst), .a(a4), .b(b4), .cin(c4), .sum(s4), .carry(k4));
  full_adder #(.WIDTH(8)) d8 (.clk(clk), .rst(rst), .a(a8), .b(b8), .cin(c8), .sum(s8), .carry(k8));
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic settle();
`ifdef FULL_ADDER_REG_OUT_EN
    @(posedge clk);
    #1;
`else
    #10;
`endif
  endtask
  initial begin
    // {a, b, cin, sum, carry}
    tt = '{5'b000_00, 5'b001_10, 5'b010_10, 5'b011_01, 5'b100_10, 5'b101_01, 5'b110_01, 5'b111_11};
    // {a, b, cin, expected 9-bit {carry, sum}}
    v8 = '{{8'hFF, 8'h01, 1'b0, 9'h100}, {8'hFF, 8'hFF, 1'b1, 9'h1FF}, {8'h80, 8'h80, 1'b0, 9'h100},
           {8'h55, 8'hAA, 1'b1, 9'h100}, {8'h12, 8'h34, 1'b0, 9'h046}, {8'h00, 8'h00, 1'b0, 9'h000}};
    {a1, b1, c1} = 3'b111;
    {a4, b4, c4} = '0;
    {a8, b8, c8} = '0;
    repeat (2) @(posedge clk);
    #1;
`ifdef FULL_ADDER_REG_OUT_EN
    check("reset", {s1, k1}, 2'b00);
    rst = 1'b0;
    {a1, b1, c1} = 3'b110;
    #1;
    check("early", {s1, k1}, 2'b00);
    @(posedge clk);
    #1;
    check("first", {s1, k1}, 2'b01);
    {a1, b1, c1} = 3'b111;
    settle();
    check("pre_rst", {s1, k1}, 2'b11);
    rst = 1'b1;
    settle();
    check("mid_rst", {s1, k1}, 2'b00);
    rst = 1'b0;
    settle();
    check("post_rst", {s1, k1}, 2'b11);
`else
    check("rst_ignored", {s1, k1}, 2'b11);
    rst = 1'b0;
`endif
    for (int i = 0; i < 8; i++) begin
      {a1, b1, c1} = tt[i][4:2];
      settle();
      check($sformatf("tt%0d", i), {s1, k1}, tt[i][1:0]);
    end
    a4 = 4'hF; b4 = 4'h0; c4 = 1'b1;
    settle();
    check("w4_ripple", {k4, s4}, 5'h10);
    a4 = 4'h7; b4 = 4'h8; c4 = 1'b0;
    settle();
    check("w4_nocarry", {k4, s4}, 5'h0F);
    for (int i = 0; i < 6; i++) begin
      {a8, b8, c8} = v8[i][25:9];
      settle();
      check($sformatf("w8_dir%0d", i), {k8, s8}, v8[i][8:0]);
    end
    for (int i = 0; i < 1000; i++) begin
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      c8 = 1'($urandom);
      ref9 = {1'b0, a8} + {1'b0, b8} + {8'h00, c8};
      settle();
      check($sformatf("w8_rnd%0d", i), {k8, s8}, ref9);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
